// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// default bus widths and a small state-decoding helper.
package arb_pkg;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_STARVE_MAX = 4;

    // Arbiter FSM states; encodings are fixed so they stay stable across tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    // A memory transaction is outstanding in every state except IDLE.
    function automatic logic arb_busy(input arb_state_e state);
        arb_busy = (state != IDLE);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Fetch starvation counter: counts data grants that are made while a fetch
// is waiting, clears on any fetch grant and saturates at MAX. o_starved
// tells the arbiter that the fetch side must win the next arbitration.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_data_grant_while_fetch,
    input  logic i_fetch_grant,
    output logic o_starved
);

    localparam int            CW    = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] r_count;

    // Count data grants that bypass a waiting fetch; clear on fetch grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_fetch_grant) begin
            r_count <= '0;
        end else if (i_data_grant_while_fetch && (r_count != MAX_C)) begin
            r_count <= r_count + ONE_C;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_starved = (r_count == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single
// memory port. Data has priority over fetch. Defining ARB_FAIR_EN adds a
// starvation counter that forces a fetch grant after STARVE_MAX consecutive
// data grants made while a fetch was waiting.
// Arbitration runs in IDLE and in every cycle a transaction completes, so
// back-to-back transactions have no idle bubble. A requester whose ready is
// high this cycle is masked, because its req is still the completed one.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_ack_live;
    logic w_arb_en;
    logic w_if_cand;
    logic w_dm_cand;
    logic w_fetch_win;
    logic w_data_win;
    logic w_starved;

`ifdef ARB_FAIR_EN
    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve_counter (
        .clk                      (clk),
        .rst_n                    (reset),
        .i_data_grant_while_fetch (w_data_win & w_if_cand),
        .i_fetch_grant            (w_fetch_win),
        .o_starved                (w_starved)
    );
`else
    assign w_starved = 1'b0;
`endif

    // Pick the winner of this cycle's arbitration (if arbitration runs).
    always_comb begin
        w_ack_live  = mem_ack & arb_busy(r_state);
        w_arb_en    = (r_state == IDLE) | w_ack_live;
        w_if_cand   = if_req & ~r_if_ready;
        w_dm_cand   = dm_req & ~r_dm_ready;
        w_fetch_win = 1'b0;
        w_data_win  = 1'b0;
        if (w_arb_en) begin
            if (w_if_cand & (~w_dm_cand | w_starved)) begin
                w_fetch_win = 1'b1;
            end else if (w_dm_cand) begin
                w_data_win = 1'b1;
            end else begin
                w_fetch_win = 1'b0;
                w_data_win  = 1'b0;
            end
        end else begin
            w_fetch_win = 1'b0;
            w_data_win  = 1'b0;
        end
    end

    // Next FSM state: enter the winner's state, or drop to IDLE on completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FETCH, DATA: begin
                if (w_fetch_win) begin
                    w_state_nxt = FETCH;
                end else if (w_data_win) begin
                    w_state_nxt = DATA;
                end else if (w_arb_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion pulses and captured read data for each requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ready <= w_ack_live & (r_state == FETCH);
            r_dm_ready <= w_ack_live & (r_state == DATA);
            if (w_ack_live && (r_state == FETCH)) begin
                r_if_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= r_if_rdata;
            end
            if (w_ack_live && (r_state == DATA)) begin
                r_dm_rdata <= mem_rdata;
            end else begin
                r_dm_rdata <= r_dm_rdata;
            end
        end
    end

    // Memory command registers, loaded at grant and held until completion.
    // A fetch drives zero write data; the write enable is cleared when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_fetch_win) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
        end else if (w_data_win) begin
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
        end else if (w_ack_live) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
        end else begin
            r_mem_we    <= r_mem_we;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
        end
    end

    assign mem_req   = arb_busy(r_state);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_f   = if_req & ~r_if_ready;
    assign stall_m   = dm_req & ~r_dm_ready;

endmodule
